// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the baud divider rule,
// so uart_tx and uart_rx always agree on bit timing.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Integer divide: any fractional remainder becomes per-frame drift.
    function automatic int ticks_per_bit(input int clk_hz, input int baud_hz);
        return clk_hz / baud_hz;
    endfunction

    function automatic int half_bit(input int clk_hz, input int baud_hz);
        return ticks_per_bit(clk_hz, baud_hz) >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handoff between uart_rx (master) and its consumer (slave).
// Byte is held until acknowledged; no backpressure reaches the serial line.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rd_ack;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 overrun;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rd_ack,
        output data, valid, overrun, frame_err, busy
    );

    modport slave (
        output rd_ack,
        input  data, valid, overrun, frame_err, busy
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous pins; 2-cycle latency, no handshake.
// Reset value is a parameter so idle-high lines do not fake an edge at reset release.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with centre sampling; byte valid one cycle after the stop-bit sample.
// Output register holds until rd_ack; an unacknowledged byte is overwritten and flags overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY  = 66_000_000,
    parameter int UART_FREQUENCY = 921_600
) (
    input  logic     user_clk,
    input  logic     rst,
    input  logic     rx_bit,
    uart_rx_if.master bus
);

    localparam int TICKS_PER_BIT = ticks_per_bit(CLK_FREQUENCY, UART_FREQUENCY);
    localparam int HALF_BIT      = half_bit(CLK_FREQUENCY, UART_FREQUENCY);
    localparam int CNT_W         = $clog2(TICKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] START = ST_START;
    localparam logic [1:0] DATA  = ST_DATA;
    localparam logic [1:0] STOP  = ST_STOP;

    logic                 rx_s;
    logic                 rx_q;
    logic [1:0]           state;
    logic [CNT_W-1:0]     clk_count;
    logic [2:0]           bit_count;
    logic [DATA_BITS-1:0] shreg;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 overrun_q;
    logic                 frame_err_q;

    logic sample_stop;
    logic stop_ok;
    logic stop_bad;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (user_clk),
        .rst (rst),
        .d   (rx_bit),
        .q   (rx_s)
    );

    assign sample_stop = (state == STOP) && (clk_count == BIT_LAST);
    assign stop_ok     = sample_stop &&  rx_s;
    assign stop_bad    = sample_stop && !rx_s;

    // Start hunting needs a genuine 1->0 edge, so a stuck-low line never retriggers.
    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            rx_q      <= 1'b1;
            state     <= IDLE;
            clk_count <= '0;
            bit_count <= '0;
            shreg     <= '0;
        end else begin
            rx_q <= rx_s;
            case (state)
                IDLE: begin
                    if (rx_q && !rx_s) begin
                        state     <= START;
                        clk_count <= '0;
                    end
                end
                START: begin
                    if (clk_count == HALF_LAST) begin
                        clk_count <= '0;
                        bit_count <= '0;
                        state     <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_count == BIT_LAST) begin
                        clk_count        <= '0;
                        shreg[bit_count] <= rx_s;
                        if (bit_count == LAST_BIT) begin
                            bit_count <= '0;
                            state     <= STOP;
                        end else begin
                            bit_count <= bit_count + 1'b1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_count == BIT_LAST) begin
                        clk_count <= '0;
                        state     <= IDLE;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    clk_count <= '0;
                    bit_count <= '0;
                end
            endcase
        end
    end

    // A completing byte takes priority over rd_ack; an ack in the same cycle only suppresses overrun.
    always_ff @(posedge user_clk or posedge rst) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            if (stop_ok) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
                if (valid_q) begin
                    overrun_q <= !bus.rd_ack;
                end
            end else if (bus.rd_ack && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver paired with the `uart_tx` transmitter: same 8N1 framing, same clock, and a baud rate set by the same divider rule. It synchronises the asynchronous serial line and hunts for start bits. Each bit is sampled at its centre, and completed bytes are presented on a hold-until-acknowledged output register. The block sits between the board RX pin and the capture/control logic that consumes host commands.

## Interface
- `CLK_FREQUENCY`, 66_000_000, fpga clock frequency in Hz
- `UART_FREQUENCY`, 921_600, baud rate in Hz; `TICKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY` (integer divide, 71 at defaults); `HALF_BIT = TICKS_PER_BIT >> 1` (35)
- `user_clk`  in  1  the single clock
- `rst`  in  1  reset, asynchronous and active-high
- `rx_bit`  in  1  serial line, idle high, asynchronous to `user_clk`
- `rd_ack`  in  1  consumer acknowledges the byte on `data`; clears `valid`
- `data`  out  8  last received byte, LSB first on the line
- `valid`  out  1  `data` holds an unacknowledged byte
- `overrun`  out  1  sticky: a byte completed while `valid` was already 1
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `busy`  out  1  FSM not in IDLE

## Operation
- Reset values: `data`=0, `valid`=0, `overrun`=0, `frame_err`=0, `busy`=0. Both synchroniser flops and the previous-sample flop reset to 1. FSM resets to IDLE, and both counters reset to 0.
- `rx_bit` passes through a 2-flop synchroniser to `rx_s`. A previous-sample flop `rx_q` feeds falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_q`=1 and `rx_s`=0, go to START with `clk_count`=0. A line held low never retriggers; a fresh 1→0 edge is required.
  - START: `clk_count` increments. At `clk_count == HALF_BIT-1`, sample `rx_s`:
    - 0: go to DATA with `clk_count`=0 and `bit_count`=0.
    - 1: false start; return to IDLE. No output changes.
  - DATA: at `clk_count == TICKS_PER_BIT-1`, shift `rx_s` into the shift register at position `bit_count` (LSB first). Then clear `clk_count` and increment `bit_count`. After bit 7, go to STOP.
  - STOP: at `clk_count == TICKS_PER_BIT-1`, sample `rx_s`, then return to IDLE:
    - 1: `data` ← shift register and `valid` ← 1. If `valid` was already 1 and `rd_ack`=0 in this cycle, `overrun` ← 1 and `data` is overwritten.
    - 0: pulse `frame_err` for one cycle. `data`, `valid` and `overrun` are unchanged.
- `rd_ack` while `valid`=1: clears `valid` and `overrun` on the next edge. `rd_ack` while `valid`=0 is ignored.
- Byte completion and `rd_ack` in the same cycle: the new byte wins. `valid` stays 1 and `overrun` is not set.
- Counter widths: `clk_count` is `$clog2(TICKS_PER_BIT)` bits; `bit_count` is 3 bits. Neither wraps beyond its compare value.
- `rst` mid-frame: the partial byte is discarded, and all outputs and state return to reset values immediately.

## Timing
- E0 is the first `user_clk` edge at which synchroniser stage 1 captures `rx_bit`=0.
  - E2: IDLE→START.
  - E37: start-bit check.
  - E108 + 71·n: data bit n sampled, n = 0..7.
  - E676: stop bit sampled.
  - `valid` or `frame_err` is visible in the cycle after E676.
- Centre sampling tolerates ±35 cycles of accumulated drift per frame at the defaults.
- After E676 the FSM is in IDLE and accepts a new start edge on the next cycle. Back-to-back frames with one stop bit are received without loss.
- `valid` falls in the cycle after `rd_ack` is sampled high.

## Structure
- Shared package `uart_pkg`:
  - state encoding enum (IDLE/START/DATA/STOP)
  - `TICKS_PER_BIT` / `HALF_BIT` derivation as functions of the two frequencies, shared with `uart_tx`
- One sub-module: `sync_2ff` (parameterised reset value, here 1), reused for any other asynchronous pins.

## Test plan
- Defaults, `uart_tx` loopback sends 0xA5 → `valid` rises after E676, `data`=0xA5, `frame_err`=0, `overrun`=0; `rd_ack` pulse → `valid`=0 next cycle.
- 10-cycle low glitch on idle line → FSM returns to IDLE at E37; no `valid`, no `frame_err`; a following 0x3C frame is received correctly.
- Frame 0x81 with the stop bit forced low → single-cycle `frame_err`; `data` keeps its previous value, `valid` unchanged; the next good frame 0x7E is received.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap, `rd_ack` after each → three `valid` events with the correct bytes.
- Two frames, no `rd_ack` → `overrun`=1, `data`=second byte; `rd_ack` clears both; completion and `rd_ack` in the same cycle → `valid`=1, `overrun`=0.
- Assert `rst` during DATA bit 4 → all outputs at reset values immediately; after release, a fresh 0xC3 frame is received correctly.
